bus_cycle_ctl: RTL and testbench
================================

// Module: bus_cycle_ctl
// PURPOSE
//  Memory-cycle sequencer directly upstream of the per-bit data latch array.
//  Turns one core access request (read/write) into a 4-T-state ASIC bus cycle.
//  Drives the address bus, nRD/nWR strobes, the latch bus-connect control
//  (DL_Control1, active-low), the write-data drive and the read-data capture.
//  Supports external wait states with a timeout.
// PARAMETERS
//  ADDR_W    16  address width
//  DATA_W     8  data width
//  MAX_WAIT  15  wait cycles tolerated in T2 before abort (1..255)
// PORTS
//  CLK        in   1       system clock; all state changes on posedge
//  RESET      in   1       synchronous reset, active-high
//  req        in   1       core access request, sampled in IDLE or T4
//  we         in   1       1=write, 0=read; sampled with req
//  addr       in   ADDR_W  access address; sampled with req
//  wdata      in   DATA_W  write data; sampled with req
//  busy       out  1       high from the cycle req is accepted until ack
//  ack        out  1       1-cycle pulse in T4: access complete
//  err        out  1       1-cycle pulse with ack when the wait timeout aborts
//  rdata      out  DATA_W  captured read data; held until next read capture
//  A          out  ADDR_W  ASIC address bus
//  nRD        out  1       read strobe, active-low
//  nWR        out  1       write strobe, active-low
//  DL_Control1 out 1       latch bus connect, active-low (0 = core on DataBus)
//  db_out     out  DATA_W  write data toward DataBus
//  db_oe      out  1       db_out drive enable
//  db_in      in   DATA_W  DataBus sampled value
//  wait_n     in   1       0 = peripheral requests a wait state
// BEHAVIOUR
//  Reset values: state=IDLE, busy=0, ack=0, err=0, rdata=0, A=0, nRD=1, nWR=1,
//   DL_Control1=1, db_oe=0, db_out=0, wait counter=0.
//  FSM (registered outputs, one state per CLK):
//   IDLE: req=1 -> latch addr/we/wdata, go T1, busy=1; else stay.
//   T1: A=addr, DL_Control1=0; strobes still high -> T2.
//   T2: nRD=~(!we) / nWR=~we asserted; write: db_oe=1, db_out=wdata.
//       wait_n=0 -> stay T2, wcnt++; wcnt==MAX_WAIT -> abort to T4 with err.
//       wait_n=1 -> T3.
//   T3: read: rdata<=db_in at end of T3; strobes stay asserted -> T4.
//   T4: strobes deasserted, db_oe=0, DL_Control1=1, ack=1 (err=1 if aborted).
//       req=1 -> accept new request, go T1 (back-to-back, no IDLE bubble);
//       else -> IDLE, busy=0.
//  Latency: zero-wait access = 4 cycles req-accept to ack (T1..T4);
//   each wait cycle adds 1; abort ack arrives MAX_WAIT+2 cycles after T1... fixed
//   as T1, MAX_WAIT+1 cycles in T2, then T4.
//  Aborted read leaves rdata unchanged; aborted write still releases the bus.
//  req while busy outside T4 is ignored (not queued); core holds req until ack.
//  addr/we/wdata changes while busy have no effect (captured copies used).
//  nRD and nWR never low in the same cycle; db_oe never 1 on a read.
//  wcnt clears on every entry to T1; saturates, never wraps.
//  RESET mid-cycle: next edge forces all reset values; no ack, no err.
// TESTING
//  1 read, addr=16'hFF80, wait_n=1, db_in=8'h5A -> ack 4 cycles after accept,
//    rdata=8'h5A, nRD low in T2-T3 only, nWR high throughout.
//  2 write, addr=16'hC000, wdata=8'hA5 -> db_oe=1 and db_out=8'hA5 in T2-T3,
//    nWR low T2-T3, ack in T4, rdata unchanged.
//  3 read with wait_n=0 for 3 cycles -> ack at cycle 7, err=0, data valid.
//  4 wait_n held 0 -> abort after MAX_WAIT=15: ack=1,err=1, strobes released.
//  5 req held high through T4 -> next T1 immediately, busy stays 1, A updates.
//  6 RESET asserted in T2 of a write -> next cycle nWR=1, db_oe=0,
//    DL_Control1=1, busy=0, no ack.

Source files
------------

// File: rtl/bus_cycle_ctl.sv
// Memory-cycle sequencer: one core read/write becomes a 4-T-state ASIC bus cycle.
// Latency: 4 cycles accept-to-ack with zero waits, +1 per wait state, MAX_WAIT+3 on abort.
// Backpressure: wait_n=0 stretches T2; req is only sampled in IDLE/T4, ignored while busy.
//
// Ports:
//   CLK, RESET            clock, synchronous active-high reset
//   req/we/addr/wdata     core request, captured on acceptance
//   busy/ack/err/rdata    core status, completion pulse, timeout flag, read data
//   A/nRD/nWR             ASIC address bus and active-low strobes
//   DL_Control1           latch bus connect, active-low (0 = core on DataBus)
//   db_out/db_oe/db_in    DataBus write drive, drive enable, sampled read value
//   wait_n                0 = peripheral inserts a wait state in T2

module bus_cycle_ctl #(
    parameter int ADDR_W   = 16,
    parameter int DATA_W   = 8,
    parameter int MAX_WAIT = 15
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              req,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              busy,
    output logic              ack,
    output logic              err,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] A,
    output logic              nRD,
    output logic              nWR,
    output logic              DL_Control1,
    output logic [DATA_W-1:0] db_out,
    output logic              db_oe,
    input  logic [DATA_W-1:0] db_in,
    input  logic              wait_n
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_T1   = 3'd1,
        S_T2   = 3'd2,
        S_T3   = 3'd3,
        S_T4   = 3'd4
    } state_t;

    localparam logic [7:0] LP_MAX_WAIT = 8'(MAX_WAIT);

    // current registered state and outputs
    state_t              r_state;
    logic                r_we;
    logic [DATA_W-1:0]   r_wdata;
    logic [7:0]          r_wcnt;
    logic                r_busy;
    logic                r_ack;
    logic                r_err;
    logic [DATA_W-1:0]   r_rdata;
    logic [ADDR_W-1:0]   r_a;
    logic                r_nrd;
    logic                r_nwr;
    logic                r_dl;
    logic [DATA_W-1:0]   r_db_out;
    logic                r_db_oe;

    // next-state values
    state_t              w_state;
    logic                w_we;
    logic [DATA_W-1:0]   w_wdata;
    logic [7:0]          w_wcnt;
    logic                w_busy;
    logic                w_ack;
    logic                w_err;
    logic [DATA_W-1:0]   w_rdata;
    logic [ADDR_W-1:0]   w_a;
    logic                w_nrd;
    logic                w_nwr;
    logic                w_dl;
    logic [DATA_W-1:0]   w_db_out;
    logic                w_db_oe;
    logic                w_accept;

    // T4 is the only state besides IDLE that can take a new request,
    // which gives back-to-back cycles without an IDLE bubble.
    assign w_accept = req && ((r_state == S_IDLE) || (r_state == S_T4));

    always_comb begin
        w_state  = r_state;
        w_we     = r_we;
        w_wdata  = r_wdata;
        w_wcnt   = r_wcnt;
        w_busy   = r_busy;
        w_ack    = 1'b0;
        w_err    = 1'b0;
        w_rdata  = r_rdata;
        w_a      = r_a;
        w_nrd    = r_nrd;
        w_nwr    = r_nwr;
        w_dl     = r_dl;
        w_db_out = r_db_out;
        w_db_oe  = r_db_oe;

        case (r_state)
            S_IDLE: begin
                // acceptance handled below
            end

            S_T1: begin
                // assert exactly one strobe; drive data only for writes
                w_state = S_T2;
                w_nrd   = r_we;
                w_nwr   = ~r_we;
                w_db_oe = r_we;
                if (r_we) begin
                    w_db_out = r_wdata;
                end
            end

            S_T2: begin
                if (wait_n) begin
                    w_state = S_T3;
                end else if (r_wcnt == LP_MAX_WAIT) begin
                    // timeout: skip T3 so an aborted read never touches rdata
                    w_state = S_T4;
                    w_nrd   = 1'b1;
                    w_nwr   = 1'b1;
                    w_db_oe = 1'b0;
                    w_dl    = 1'b1;
                    w_ack   = 1'b1;
                    w_err   = 1'b1;
                end else if (r_wcnt != 8'hFF) begin
                    w_wcnt = r_wcnt + 8'd1;
                end
            end

            S_T3: begin
                w_state = S_T4;
                if (!r_we) begin
                    w_rdata = db_in;
                end
                w_nrd   = 1'b1;
                w_nwr   = 1'b1;
                w_db_oe = 1'b0;
                w_dl    = 1'b1;
                w_ack   = 1'b1;
            end

            S_T4: begin
                w_state = S_IDLE;
                w_busy  = 1'b0;
            end

            default: begin
                w_state = S_IDLE;
                w_busy  = 1'b0;
            end
        endcase

        // new cycle: capture request, present address, connect latch bus
        if (w_accept) begin
            w_state = S_T1;
            w_busy  = 1'b1;
            w_we    = we;
            w_wdata = wdata;
            w_a     = addr;
            w_dl    = 1'b0;
            w_wcnt  = 8'd0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state  <= S_IDLE;
            r_we     <= 1'b0;
            r_wdata  <= '0;
            r_wcnt   <= 8'd0;
            r_busy   <= 1'b0;
            r_ack    <= 1'b0;
            r_err    <= 1'b0;
            r_rdata  <= '0;
            r_a      <= '0;
            r_nrd    <= 1'b1;
            r_nwr    <= 1'b1;
            r_dl     <= 1'b1;
            r_db_out <= '0;
            r_db_oe  <= 1'b0;
        end else begin
            r_state  <= w_state;
            r_we     <= w_we;
            r_wdata  <= w_wdata;
            r_wcnt   <= w_wcnt;
            r_busy   <= w_busy;
            r_ack    <= w_ack;
            r_err    <= w_err;
            r_rdata  <= w_rdata;
            r_a      <= w_a;
            r_nrd    <= w_nrd;
            r_nwr    <= w_nwr;
            r_dl     <= w_dl;
            r_db_out <= w_db_out;
            r_db_oe  <= w_db_oe;
        end
    end

    assign busy        = r_busy;
    assign ack         = r_ack;
    assign err         = r_err;
    assign rdata       = r_rdata;
    assign A           = r_a;
    assign nRD         = r_nrd;
    assign nWR         = r_nwr;
    assign DL_Control1 = r_dl;
    assign db_out      = r_db_out;
    assign db_oe       = r_db_oe;

endmodule

// File: tb/tb_bus_cycle_ctl.sv
module tb_bus_cycle_ctl;

    localparam int ADDR_W   = 16;
    localparam int DATA_W   = 8;
    localparam int MAX_WAIT = 15;

    logic              CLK = 1'b0;
    logic              RESET;
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              busy;
    logic              ack;
    logic              err;
    logic [DATA_W-1:0] rdata;
    logic [ADDR_W-1:0] A;
    logic              nRD;
    logic              nWR;
    logic              DL_Control1;
    logic [DATA_W-1:0] db_out;
    logic              db_oe;
    logic [DATA_W-1:0] db_in;
    logic              wait_n;

    int n_checks = 0;
    int n_errors = 0;

    bus_cycle_ctl #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .MAX_WAIT(MAX_WAIT)
    ) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .req        (req),
        .we         (we),
        .addr       (addr),
        .wdata      (wdata),
        .busy       (busy),
        .ack        (ack),
        .err        (err),
        .rdata      (rdata),
        .A          (A),
        .nRD        (nRD),
        .nWR        (nWR),
        .DL_Control1(DL_Control1),
        .db_out     (db_out),
        .db_oe      (db_oe),
        .db_in      (db_in),
        .wait_n     (wait_n)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // sample point: 1 time unit after the active edge
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // One access with the request dropped right after acceptance.
    // wait_n is held low for n_wait T2 cycles; n_wait > MAX_WAIT forces a timeout.
    // Cycle k=1 is T1. Strobes are expected low from cycle 2 through the last
    // T2/T3 cycle; the ack cycle number and err flag are returned.
    task automatic do_access(input logic w, input logic [15:0] a, input logic [7:0] d,
                             input int n_wait, output int ack_k, output logic err_seen);
        int  lo_end;
        logic in_lo;
        lo_end = (n_wait > MAX_WAIT) ? (MAX_WAIT + 2) : (3 + n_wait);
        req   = 1'b1;
        we    = w;
        addr  = a;
        wdata = d;
        tick();
        // captured copies must be used from here on
        req   = 1'b0;
        we    = ~w;
        addr  = ~a;
        wdata = ~d;
        ack_k    = -1;
        err_seen = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            wait_n = (k >= 2 + n_wait) ? 1'b1 : 1'b0;
            in_lo  = (k >= 2) && (k <= lo_end);
            if (k == 1) begin
                check("t1_addr", 32'(A), 32'(a));
                check("t1_dl", 32'(DL_Control1), 0);
                check("t1_busy", 32'(busy), 1);
            end
            if (ack) begin
                ack_k    = k;
                err_seen = err;
                break;
            end
            check("nrd_cyc", 32'(nRD), 32'(!(in_lo && !w)));
            check("nwr_cyc", 32'(nWR), 32'(!(in_lo && w)));
            check("oe_cyc", 32'(db_oe), 32'(in_lo && w));
            if (in_lo && w) check("dbout_cyc", 32'(db_out), 32'(d));
            check("a_hold", 32'(A), 32'(a));
            tick();
        end
        check("ack_seen", 32'(ack), 1);
        check("t4_nrd", 32'(nRD), 1);
        check("t4_nwr", 32'(nWR), 1);
        check("t4_oe", 32'(db_oe), 0);
        check("t4_dl", 32'(DL_Control1), 1);
        check("t4_busy", 32'(busy), 1);
        wait_n = 1'b1;
        tick();
        check("idle_busy", 32'(busy), 0);
        check("idle_ack", 32'(ack), 0);
        check("idle_err", 32'(err), 0);
    endtask

    int   ak;
    logic ae;

    initial begin
        RESET  = 1'b1;
        req    = 1'b0;
        we     = 1'b0;
        addr   = '0;
        wdata  = '0;
        db_in  = '0;
        wait_n = 1'b1;
        tick();
        tick();
        check("rst_busy", 32'(busy), 0);
        check("rst_ack", 32'(ack), 0);
        check("rst_err", 32'(err), 0);
        check("rst_rdata", 32'(rdata), 0);
        check("rst_a", 32'(A), 0);
        check("rst_nrd", 32'(nRD), 1);
        check("rst_nwr", 32'(nWR), 1);
        check("rst_dl", 32'(DL_Control1), 1);
        check("rst_oe", 32'(db_oe), 0);
        check("rst_dbout", 32'(db_out), 0);
        RESET = 1'b0;
        tick();
        check("idle_hold_busy", 32'(busy), 0);

        // 1: zero-wait read
        db_in = 8'h5A;
        do_access(1'b0, 16'hFF80, 8'h00, 0, ak, ae);
        check("rd_ack_cyc", 32'(ak), 4);
        check("rd_err", 32'(ae), 0);
        check("rd_data", 32'(rdata), 32'h5A);

        // 2: write, rdata must keep the earlier read value
        db_in = 8'h33;
        do_access(1'b1, 16'hC000, 8'hA5, 0, ak, ae);
        check("wr_ack_cyc", 32'(ak), 4);
        check("wr_err", 32'(ae), 0);
        check("wr_rdata_keep", 32'(rdata), 32'h5A);

        // 3: read with three wait states
        db_in = 8'h77;
        do_access(1'b0, 16'h1234, 8'h00, 3, ak, ae);
        check("wt_ack_cyc", 32'(ak), 7);
        check("wt_err", 32'(ae), 0);
        check("wt_data", 32'(rdata), 32'h77);

        // 4: wait_n held low -> timeout; aborted read leaves rdata alone
        db_in = 8'hEE;
        do_access(1'b0, 16'h0F0F, 8'h00, 100, ak, ae);
        check("ab_ack_cyc", 32'(ak), MAX_WAIT + 3);
        check("ab_err", 32'(ae), 1);
        check("ab_rdata_keep", 32'(rdata), 32'h77);

        // 4b: aborted write still releases the bus
        do_access(1'b1, 16'h00AA, 8'h3C, 100, ak, ae);
        check("abw_ack_cyc", 32'(ak), MAX_WAIT + 3);
        check("abw_err", 32'(ae), 1);

        // 5: req held through T4 -> immediate T1 for the second access
        db_in  = 8'h11;
        req    = 1'b1;
        we     = 1'b0;
        addr   = 16'h1111;
        tick();
        check("b2b_t1_a", 32'(A), 32'h1111);
        tick();
        tick();
        tick();
        check("b2b_ack1", 32'(ack), 1);
        check("b2b_rd1", 32'(rdata), 32'h11);
        addr = 16'h2222;
        we   = 1'b1;
        wdata = 8'h99;
        tick();
        check("b2b_busy", 32'(busy), 1);
        check("b2b_ack_low", 32'(ack), 0);
        check("b2b_a2", 32'(A), 32'h2222);
        check("b2b_dl2", 32'(DL_Control1), 0);
        req = 1'b0;
        tick();
        check("b2b_nwr2", 32'(nWR), 0);
        check("b2b_dbout2", 32'(db_out), 32'h99);
        tick();
        tick();
        check("b2b_ack2", 32'(ack), 1);
        tick();
        check("b2b_idle", 32'(busy), 0);

        // 6: reset in T2 of a write
        req   = 1'b1;
        we    = 1'b1;
        addr  = 16'hBEEF;
        wdata = 8'hC3;
        tick();
        req = 1'b0;
        tick();
        check("rs_t2_nwr", 32'(nWR), 0);
        check("rs_t2_oe", 32'(db_oe), 1);
        RESET = 1'b1;
        tick();
        check("rs_nwr", 32'(nWR), 1);
        check("rs_oe", 32'(db_oe), 0);
        check("rs_dl", 32'(DL_Control1), 1);
        check("rs_busy", 32'(busy), 0);
        check("rs_ack", 32'(ack), 0);
        check("rs_err", 32'(err), 0);
        check("rs_rdata", 32'(rdata), 0);
        RESET = 1'b0;
        tick();
        check("rs_stay_idle", 32'(busy), 0);
        check("rs_no_ack", 32'(ack), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
